b02_bcd_serial_tx: RTL and testbench
====================================

# b02_bcd_serial_tx

Serial BCD digit transmitter: the sending end of the b02 serial-line protocol. It accepts 4-bit digits over a valid/ready handshake and buffers them in a small FIFO. Each digit is shifted onto the single-bit `linea` line as a contiguous 4-bit group, MSB first, back-to-back with no gap. It produces the stimulus stream consumed by the b02 BCD recognizer and filters out non-BCD codes before they reach the line.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2 to 16.
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `in_digit` in 4: digit to send; legal values 0–9.
- `in_valid` in 1: `in_digit` is valid.
- `in_ready` out 1: block can accept a digit this cycle.
- `linea` out 1: serial data line, registered.
- `frame` out 1: high while `linea` carries bit 3 (first bit) of a digit.
- `busy` out 1: FIFO non-empty or shifter active.
- `err` out 1: one-cycle pulse; a non-BCD digit (10–15) was accepted and discarded.

## Operation
- **Handshake.** A transfer occurs at a rising edge with `in_valid` and `in_ready` both high.
  - `in_ready` = !fifo_full && !reset. It does not depend on `in_valid`.
  - `in_digit` ≤ 9: the digit is pushed to the FIFO.
  - `in_digit` ≥ 10: the digit is consumed but not pushed, and `err` is high for the following cycle.
- **FSM states.** IDLE, SHIFT.
  - IDLE: `linea` = 0, `frame` = 0.
  - IDLE → SHIFT at an edge when the FIFO is non-empty. The head is popped into the shift register and bit counter = 3. `linea` = bit3 and `frame` = 1 from that edge.
  - SHIFT: each edge decrements the counter and drives the next lower bit. `frame` = 0 for bits 2..0.
  - At the edge ending bit 0: if the FIFO is non-empty, pop the next digit and drive its bit 3 immediately (stay in SHIFT, `frame` = 1). Otherwise go to IDLE.
- **Simultaneous push and pop.** Both are allowed in one cycle. Occupancy is unchanged.
  - `in_ready` reflects the pre-edge full flag, so no push is accepted while full, even on a pop cycle.
- **Empty FIFO.** A digit pushed at edge E into an empty FIFO while IDLE is popped at edge E+1. There is no FIFO bypass.
- **Pointers and occupancy.** FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
- **Reset.** Reset mid-digit aborts the transmission and empties the FIFO; partial groups are not completed. The whole block returns to its reset values at the reset edge.
- **Reset values.** `linea` 0, `frame` 0, `busy` 0, `err` 0, state IDLE, FIFO empty. `in_ready` is 0 while `reset` is high and 1 in the first cycle after.

## Timing
- **Accept → first bit.** Push at edge E, pop at E+1. `linea` carries bit 3 during the cycle E+1..E+2.
- **Per digit.** Exactly 4 cycles on the line. N queued digits occupy 4N contiguous cycles.
- **Throughput.** Sustained rate is 1 digit per 4 cycles. The FIFO absorbs bursts up to DEPTH digits beyond the one in the shifter.
- **`busy`.** Registered. Rises the edge after the first push; falls the edge the shifter returns to IDLE with an empty FIFO.
- **`err`.** Registered. High for exactly one cycle after the offending transfer.

## Structure
- **Package `b02_pkg`.**
  - `DIGIT_W` = 4, `BCD_MAX` = 9.
  - `tx_state_t` enum {IDLE, SHIFT}.
  - Bit-counter width constant.
- **Sub-module `b02_digit_fifo`.** Synchronous FIFO parameterized by DEPTH and width.
  - Ports: push, pop, din, dout, full, empty.
  - Registered storage; dout = head entry, combinational read.
- **Top level.** Holds the handshake filter, FSM, shift register and output registers.

## Test plan
- **Single digit.** Reset, then push 5 (0101) at edge E → `linea` = 0,1,0,1 on cycles E+1..E+4. `frame` is high only on E+1. `busy` is 0 again after E+5.
- **Back-to-back.** Push 9, 3, 0 on consecutive cycles → 12 contiguous line bits 1001 0011 0000. `frame` is high on every 4th cycle, with no idle bit between groups.
- **Non-BCD filter.** Push 12 then 7 → `err` is high one cycle, and only 0111 is transmitted.
- **Full FIFO (DEPTH = 4).** Hold `in_valid` with digits 1..9 → `in_ready` drops after the FIFO fills. Accepted digits are transmitted in order with none lost or duplicated. `in_ready` reasserts the cycle after the first pop that leaves room.
- **Reset mid-operation.** Reset during bit 2 of digit 6 with 2 digits queued → the next cycle shows `linea` 0, `busy` 0 and `in_ready` 0 while reset is held. After release, a push of 4 transmits cleanly as 0100.
- **Simultaneous push/pop.** Push on the same edge as a pop with the FIFO at DEPTH−1 → occupancy is unchanged and order is preserved.

Source files
------------

// File: rtl/b02_pkg.sv
// Shared constants and types for the b02 serial BCD transmitter.
package b02_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_MAX = 9;
  // Bit counter spans DIGIT_W positions (3..0).
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } tx_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/b02_digit_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head read.
module b02_digit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/b02_bcd_serial_tx.sv
// Serial BCD transmitter: filters non-BCD input, queues digits and shifts
// each one MSB first onto linea as a contiguous 4-bit group.
module b02_bcd_serial_tx
  import b02_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               linea,
  output logic               frame,
  output logic               busy,
  output logic               err
);

  logic               accept, push, pop, load;
  logic [DIGIT_W-1:0] fifo_dout;
  logic               fifo_full, fifo_empty;

  tx_state_t          state_q, state_d;
  logic [DIGIT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               linea_q, linea_d;
  logic               frame_q, frame_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  // Non-BCD codes are consumed from the handshake but never queued.
  assign in_ready = !fifo_full && !reset;
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_bcd(in_digit);
  assign err_d    = accept && !is_bcd(in_digit);

  b02_digit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DIGIT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_digit),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: load a digit whenever the line is free or a group just ended.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    linea_d = 1'b0;
    frame_d = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          linea_d = shreg_q[DIGIT_W-2];
          shreg_d = {shreg_q[DIGIT_W-2:0], 1'b0};
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      shreg_d = fifo_dout;
      cnt_d   = CNT_W'(DIGIT_W - 1);
      linea_d = fifo_dout[DIGIT_W-1];
      frame_d = 1'b1;
    end
    pop = load;
    // Going IDLE implies the FIFO was empty, so only a push keeps it busy.
    busy_d = (state_d == SHIFT) || push;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      linea_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      linea_q <= linea_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign linea = linea_q;
  assign frame = frame_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_b02_bcd_serial_tx.sv
// Self-checking bench for b02_bcd_serial_tx: per-cycle vector table plus
// hand-written full-FIFO, simultaneous push/pop and mid-digit reset sequences.
module tb_b02_bcd_serial_tx;

  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic       in_ready, linea, frame, busy, err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] dig;
    logic       l, f, b, e, r;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] rx_q[$];

  b02_bcd_serial_tx #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_digit (in_digit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .linea    (linea),
    .frame    (frame),
    .busy     (busy),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic vld, input logic [3:0] dig,
                     input logic l, input logic f, input logic b, input logic e,
                     input logic r);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dig = dig;
    v.l = l; v.f = f; v.b = b; v.e = e; v.r = r;
    vecs.push_back(v);
  endtask

  // Line receiver: rebuilds digits from frame/linea, flags misaligned frames and stray bits.
  initial begin
    int         bitpos;
    logic [3:0] sh;
    bitpos = 0;
    sh = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bitpos = 0;
      end else if (frame) begin
        check("frame_align", bitpos, 0);
        sh = {3'b000, linea};
        bitpos = 1;
      end else if (bitpos != 0) begin
        sh = {sh[2:0], linea};
        bitpos++;
        if (bitpos == 4) begin
          rx_q.push_back(sh);
          bitpos = 0;
        end
      end else begin
        check("idle_line", linea, 0);
      end
    end
  end

  logic       rdy_hist[8];
  logic       s_vld[7];
  logic [3:0] s_dig[7];

  initial begin
    int   next_d, c, first, last;
    logic pre_rdy;

    // rst vld dig | linea frame busy err rdy
    add(1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 5,  0, 0, 1, 0, 1);   // push 5
    add(0, 0, 0,  0, 1, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 1);
    add(0, 1, 9,  0, 0, 1, 0, 1);   // push 9, 3, 0 back to back
    add(0, 1, 3,  1, 1, 1, 0, 1);
    add(0, 1, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  0, 1, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  0, 1, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 1);
    add(0, 1, 12, 0, 0, 0, 1, 1);   // non-BCD dropped
    add(0, 1, 7,  0, 0, 1, 0, 1);
    add(0, 0, 0,  0, 1, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  1, 0, 1, 0, 1);
    add(0, 0, 0,  0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      in_valid = vecs[i].vld;
      in_digit = vecs[i].dig;
      tick();
      check($sformatf("v%0d_linea", i), linea, vecs[i].l);
      check($sformatf("v%0d_frame", i), frame, vecs[i].f);
      check($sformatf("v%0d_busy", i), busy, vecs[i].b);
      check($sformatf("v%0d_err", i), err, vecs[i].e);
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].r);
    end
    in_valid = 1'b0;
    in_digit = 4'd0;

    // Full FIFO: offer 1..9 continuously, advancing only on accepted transfers.
    rx_q.delete();
    next_d = 1;
    c = 0;
    first = -1;
    last = -1;
    while (c < 200 && (next_d <= 9 || busy)) begin
      in_valid = (next_d <= 9);
      in_digit = 4'(next_d);
      pre_rdy  = in_ready;
      tick();
      if (in_valid && pre_rdy) next_d++;
      if (c < 8) rdy_hist[c] = in_ready;
      if (frame && first < 0) first = c;
      if (busy) last = c;
      c++;
    end
    in_valid = 1'b0;
    check("full_timeout", (c < 200), 1);
    check("full_all_accepted", next_d, 10);
    check("full_rdy_e3", rdy_hist[3], 1);
    check("full_rdy_e4", rdy_hist[4], 0);
    check("full_rdy_e5", rdy_hist[5], 1);
    check("full_rdy_e6", rdy_hist[6], 0);
    check("full_line_span", last - first + 1, 36);
    check("full_rx_count", rx_q.size(), 9);
    foreach (rx_q[i]) check($sformatf("full_rx%0d", i), rx_q[i], i + 1);

    // Simultaneous push/pop with occupancy at DEPTH-1.
    s_vld = '{1, 1, 1, 1, 0, 1, 1};
    s_dig = '{4'd8, 4'd2, 4'd7, 4'd4, 4'd0, 4'd9, 4'd1};
    rx_q.delete();
    c = 0;
    while (c < 100 && (c < 7 || busy)) begin
      if (c < 7) begin
        in_valid = s_vld[c];
        in_digit = s_dig[c];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c == 5) check("pp_rdy_after_pushpop", in_ready, 1);
      if (c == 6) check("pp_rdy_full", in_ready, 0);
      c++;
    end
    in_valid = 1'b0;
    check("pp_timeout", (c < 100), 1);
    check("pp_rx_count", rx_q.size(), 6);
    if (rx_q.size() == 6) begin
      check("pp_rx0", rx_q[0], 8);
      check("pp_rx1", rx_q[1], 2);
      check("pp_rx2", rx_q[2], 7);
      check("pp_rx3", rx_q[3], 4);
      check("pp_rx4", rx_q[4], 9);
      check("pp_rx5", rx_q[5], 1);
    end

    // Reset during bit 2 of digit 6 with two digits queued.
    rx_q.delete();
    in_valid = 1'b1; in_digit = 4'd6; tick();
    in_digit = 4'd3; tick();
    in_digit = 4'd5; tick();
    in_valid = 1'b0;
    check("rst_bit2_before", linea, 1);
    reset = 1'b1;
    tick();
    check("rst_linea", linea, 0);
    check("rst_frame", frame, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_held", in_ready, 0);
    tick();
    check("rst_busy_held", busy, 0);
    check("rst_ready_held2", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_ready_release", in_ready, 1);
    in_valid = 1'b1; in_digit = 4'd4; tick();
    in_valid = 1'b0;
    check("post_busy", busy, 1);
    tick(); check("post_b3", linea, 0); check("post_frame", frame, 1);
    tick(); check("post_b2", linea, 1);
    tick(); check("post_b1", linea, 0);
    tick(); check("post_b0", linea, 0);
    tick(); check("post_idle_busy", busy, 0);
    tick();
    check("post_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) check("post_rx0", rx_q[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
